usb_in_ep_scheduler: RTL and testbench

//  Shares the device controller's IN transaction port (txdat/txdat_len/txcork/txpop/txact)

---
 rtl/usb_in_ep_scheduler.sv | 103 ++++++++++
 tb/tb_usb_in_ep_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/usb_in_ep_scheduler.sv
// usb_in_ep_scheduler: shares the controller IN port between NUM_EP endpoint sources
// Ports: clk_i/reset_i (sync, active-high); endpt_i/txact_i/txpop_i/txpktfin_i from the controller;
//   ep_txdat_i/ep_txlen_i/ep_txcork_i from the endpoints, ep_txpop_o/ep_txact_o back to them;
//   txdat_o/txdat_len_o/txcork_o to the controller; active_ep_o/busy_o/pkt_done_o/err_o status.
module usb_in_ep_scheduler #(
  parameter int NUM_EP  = 4,
  parameter int LEN_W   = 12,
  parameter int TIMEOUT = 8192
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [3:0]              endpt_i,
  input  logic                    txact_i,
  input  logic                    txpop_i,
  input  logic                    txpktfin_i,
  input  logic [8*NUM_EP-1:0]     ep_txdat_i,
  input  logic [LEN_W*NUM_EP-1:0] ep_txlen_i,
  input  logic [NUM_EP-1:0]       ep_txcork_i,
  output logic [NUM_EP-1:0]       ep_txpop_o,
  output logic [NUM_EP-1:0]       ep_txact_o,
  output logic [7:0]              txdat_o,
  output logic [LEN_W-1:0]        txdat_len_o,
  output logic                    txcork_o,
  output logic [3:0]              active_ep_o,
  output logic                    busy_o,
  output logic [NUM_EP-1:0]       pkt_done_o,
  output logic                    err_o
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [4:0] NEP = 5'(NUM_EP);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_n;
  logic txact_q, err_q, xfer, rise, valid, active, over, fwd, tmo;
  logic [3:0] sel_q, cur_ep;
  logic [LEN_W-1:0] len_q, pop_cnt, len_cur, cnt_cur;
  logic [TW-1:0] timer;
  logic [NUM_EP-1:0] done_q;
  logic [7:0] dat_a [16];
  logic [LEN_W-1:0] len_a [16];
  logic [15:0] cork_a;
  // Pad the endpoint views to all 16 selectable numbers so an invalid select reads
  // as a corked, empty endpoint without any out-of-range indexing.
  for (genvar k = 0; k < 16; k++) begin : g_pad
    if (k < NUM_EP) begin : g_ep
      assign dat_a[k]  = ep_txdat_i[8*k +: 8];
      assign len_a[k]  = ep_txlen_i[LEN_W*k +: LEN_W];
      assign cork_a[k] = ep_txcork_i[k];
    end else begin : g_none
      assign dat_a[k]  = '0;
      assign len_a[k]  = '0;
      assign cork_a[k] = 1'b1;
    end
  end
  always_comb begin
    xfer        = state == XFER;
    rise        = txact_i & ~txact_q;
    cur_ep      = xfer ? sel_q : endpt_i;
    valid       = {1'b0, cur_ep} < NEP;
    len_cur     = xfer ? len_q : len_a[cur_ep];
    cnt_cur     = xfer ? pop_cnt : '0;
    active      = (xfer | rise) & valid & ~reset_i;
    over        = txpop_i & active & (cnt_cur == len_cur);
    fwd         = txpop_i & active & ~over;
    tmo         = xfer & txact_i & (timer == TMAX);
    txdat_o     = over ? 8'h00 : dat_a[cur_ep];
    txdat_len_o = len_cur;
    txcork_o    = reset_i | cork_a[cur_ep];
    ep_txpop_o  = fwd ? NUM_EP'(1) << cur_ep : '0;
    ep_txact_o  = (xfer & valid & txact_i & ~reset_i) ? NUM_EP'(1) << sel_q : '0;
    busy_o      = xfer;
    active_ep_o = sel_q;
    pkt_done_o  = done_q;
    err_o       = err_q;
    state_n     = (!xfer && rise) ? XFER : (xfer && (!txact_i || tmo)) ? IDLE : state;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      txact_q <= 1'b0;
      sel_q   <= '0;
      len_q   <= '0;
      pop_cnt <= '0;
      timer   <= '0;
      err_q   <= 1'b0;
      done_q  <= '0;
    end else begin
      state   <= state_n;
      txact_q <= txact_i;
      err_q   <= err_q | over | tmo;
      done_q  <= (xfer && txpktfin_i && valid && !tmo) ? NUM_EP'(1) << sel_q : '0;
      if (!xfer && rise) begin
        sel_q   <= endpt_i;
        len_q   <= len_a[endpt_i];
        pop_cnt <= LEN_W'(fwd);
        timer   <= '0;
      end else if (xfer) begin
        pop_cnt <= pop_cnt + LEN_W'(fwd);
        timer   <= timer + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_usb_in_ep_scheduler.sv
// tb_usb_in_ep_scheduler: directed plus randomized checks against a transaction-level model
module tb_usb_in_ep_scheduler;
  localparam int NEP = 4;
  localparam int LW  = 12;
  localparam int TMO = 64;
  logic clk_i = 1'b0;
  logic reset_i, txact_i, txpop_i, txpktfin_i;
  logic [3:0] endpt_i;
  logic [8*NEP-1:0] ep_txdat_i;
  logic [LW*NEP-1:0] ep_txlen_i;
  logic [NEP-1:0] ep_txcork_i, ep_txpop_o, ep_txact_o, pkt_done_o;
  logic [7:0] txdat_o;
  logic [LW-1:0] txdat_len_o;
  logic txcork_o, busy_o, err_o;
  logic [3:0] active_ep_o;
  logic [7:0] dat [NEP];
  logic [LW-1:0] len [NEP];
  bit m_busy, m_prev, m_err;
  int m_sel, m_len, m_cnt, m_age;
  logic [NEP-1:0] m_done;
  int nvec = 0;
  int nmis = 0;
  always #5 clk_i = ~clk_i;
  always_comb begin
    ep_txdat_i = '0;
    ep_txlen_i = '0;
    for (int k = 0; k < NEP; k++) begin
      ep_txdat_i[8*k +: 8]   = dat[k];
      ep_txlen_i[LW*k +: LW] = len[k];
    end
  end
  usb_in_ep_scheduler #(.NUM_EP(NEP), .LEN_W(LW), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .endpt_i(endpt_i), .txact_i(txact_i),
    .txpop_i(txpop_i), .txpktfin_i(txpktfin_i), .ep_txdat_i(ep_txdat_i),
    .ep_txlen_i(ep_txlen_i), .ep_txcork_i(ep_txcork_i), .ep_txpop_o(ep_txpop_o),
    .ep_txact_o(ep_txact_o), .txdat_o(txdat_o), .txdat_len_o(txdat_len_o),
    .txcork_o(txcork_o), .active_ep_o(active_ep_o), .busy_o(busy_o),
    .pkt_done_o(pkt_done_o), .err_o(err_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One clock: check every output against the model mid-cycle, then advance the model.
  task automatic cyc();
    int cur, cnt, ln;
    bit valid, rise, can, op, fw, tmo;
    logic [31:0] e_dat, e_cork, e_pop, e_act;
    #4;
    cur   = m_busy ? m_sel : int'(endpt_i);
    valid = cur < NEP;
    rise  = txact_i && !m_prev;
    can   = (m_busy || rise) && valid && !reset_i;
    cnt   = m_busy ? m_cnt : 0;
    ln    = 0;
    if (valid) ln = m_busy ? m_len : int'(len[cur]);
    op = txpop_i && can && cnt == ln;
    fw = txpop_i && can && !op;
    e_dat  = 0;
    e_cork = 1;
    e_pop  = 0;
    e_act  = 0;
    if (valid && !op) e_dat = 32'(dat[cur]);
    if (valid && !reset_i) e_cork = 32'(ep_txcork_i[cur]);
    if (fw) e_pop = 32'(1) << cur;
    if (m_busy && valid && txact_i && !reset_i) e_act = 32'(1) << m_sel;
    chk("txdat", 32'(txdat_o), e_dat);
    chk("txdat_len", 32'(txdat_len_o), 32'(ln));
    chk("txcork", 32'(txcork_o), e_cork);
    chk("ep_txpop", 32'(ep_txpop_o), e_pop);
    chk("ep_txact", 32'(ep_txact_o), e_act);
    chk("busy", 32'(busy_o), 32'(m_busy));
    chk("err", 32'(err_o), 32'(m_err));
    chk("pkt_done", 32'(pkt_done_o), 32'(m_done));
    if (m_busy) chk("active_ep", 32'(active_ep_o), 32'(m_sel));
    @(posedge clk_i);
    if (reset_i) begin
      m_busy = 0; m_prev = 0; m_err = 0;
      m_sel = 0; m_len = 0; m_cnt = 0; m_age = 0;
      m_done = '0;
    end else begin
      tmo = m_busy && txact_i && m_age == TMO - 1;
      m_done = '0;
      if (m_busy && txpktfin_i && m_sel < NEP && !tmo) m_done[m_sel] = 1'b1;
      m_err = m_err || op || tmo;
      if (!m_busy && rise) begin
        m_busy = 1; m_sel = int'(endpt_i); m_len = ln; m_cnt = int'(fw); m_age = 0;
      end else if (m_busy) begin
        m_cnt += int'(fw);
        m_age++;
        if (!txact_i || tmo) m_busy = 0;
      end
      m_prev = txact_i;
    end
    #1;
  endtask
  task automatic step(input bit a, input bit p, input bit f);
    txact_i = a;
    txpop_i = p;
    txpktfin_i = f;
    for (int k = 0; k < NEP; k++) dat[k] = 8'($urandom);
    ep_txcork_i = NEP'($urandom);
    cyc();
  endtask
  task automatic do_reset();
    reset_i = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    reset_i = 1'b0;
  endtask
  initial begin
    reset_i = 1'b1; txact_i = 0; txpop_i = 0; txpktfin_i = 0; endpt_i = 4'd0;
    ep_txcork_i = '0;
    for (int k = 0; k < NEP; k++) begin dat[k] = 8'($urandom); len[k] = LW'(k + 1); end
    m_busy = 0; m_prev = 0; m_err = 0; m_sel = 0; m_len = 0; m_cnt = 0; m_age = 0; m_done = '0;
    @(posedge clk_i); #1;
    do_reset();
    // EP2, four bytes, completion pulse; endpoint select moves to 0 mid-transfer
    endpt_i = 4'd2; len[2] = LW'(4);
    step(1, 0, 0);
    step(1, 1, 0);
    endpt_i = 4'd0;
    step(1, 1, 0);
    len[2] = LW'(9);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    // EP1 length 2 with an over-pop, pop on the rise cycle
    endpt_i = 4'd1; len[1] = LW'(2);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    do_reset();
    // invalid endpoint
    endpt_i = 4'd7;
    step(0, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    do_reset();
    // timeout, then rise only accepted after txact falls
    endpt_i = 4'd3; len[3] = LW'(5);
    step(1, 0, 0);
    for (int i = 0; i < TMO + 4; i++) step(1, 0, i == TMO - 1);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    do_reset();
    // reset after two of eight pops
    endpt_i = 4'd3; len[3] = LW'(8);
    step(1, 1, 0);
    step(1, 1, 0);
    reset_i = 1'b1;
    step(1, 1, 0);
    reset_i = 1'b0;
    step(1, 1, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    // zero-length packet
    endpt_i = 4'd0; len[0] = '0;
    step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    do_reset();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 16 == 0) for (int k = 0; k < NEP; k++) len[k] = LW'($urandom_range(0, 6));
      endpt_i = 4'($urandom_range(0, 5));
      reset_i = $urandom_range(0, 63) == 0;
      step($urandom_range(0, 7) == 0 ? !txact_i : txact_i,
           1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
